// File: rtl/fft_peak_tracker.sv
// -----------------------------------------------------------------------------
// fft_peak_tracker
//
// Purpose:
//   Watches the FFT magnitude stream, one bin per valid beat. For each frame it
//   finds the strongest bin inside the pitch window [MIN_BIN, MAX_BIN]. It
//   compares that peak against THRESHOLD. It also tracks whether the peak has
//   stayed on the same note, within TOLERANCE bins, over consecutive frames.
//
// Configuration macro:
//   FFT_PEAK_STABILITY_EN
//     - defined:   the 4-bit stability counter drives note_stable/stable_bin.
//     - undefined: note_stable mirrors peak_present and stable_bin mirrors
//                  peak_bin. Both update together with peak_valid.
//
// Ports:
//   clk               in   system clock
//   reset             in   synchronous, active-high
//   magnitude_tdata   in   [23:0] bin magnitude (unsigned)
//   magnitude_tuser   in   [11:0] bin index 0..4095
//   magnitude_tlast   in   last bin of a frame
//   magnitude_tvalid  in   beat qualifier (no backpressure)
//   peak_bin          out  [9:0]  bin index of the frame peak
//   peak_mag          out  [23:0] magnitude of the frame peak
//   peak_valid        out  one-cycle pulse when peak outputs update
//   peak_present      out  last reported peak magnitude > THRESHOLD
//   note_stable       out  peak has held for STABLE_FRAMES frames
//   stable_bin        out  [9:0]  bin of the held note
//   frame_err         out  one-cycle pulse when a frame is aborted
//
// Latency: the tlast beat is sampled on edge N and EVAL runs during cycle
// N+1. The published values are staged on edge N+1 and become visible on the
// outputs after edge N+2.
// -----------------------------------------------------------------------------
module fft_peak_tracker #(
  parameter int unsigned MIN_BIN       = 4,
  parameter int unsigned MAX_BIN       = 511,
  parameter logic [23:0] THRESHOLD     = 24'h000400,
  parameter int unsigned STABLE_FRAMES = 3,
  parameter int unsigned TOLERANCE     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] magnitude_tdata,
  input  logic [11:0] magnitude_tuser,
  input  logic        magnitude_tlast,
  input  logic        magnitude_tvalid,
  output logic [9:0]  peak_bin,
  output logic [23:0] peak_mag,
  output logic        peak_valid,
  output logic        peak_present,
  output logic        note_stable,
  output logic [9:0]  stable_bin,
  output logic        frame_err
);

  // Reject illegal configurations at elaboration time.
  if (MAX_BIN >= 1024 || MAX_BIN < MIN_BIN) begin : g_bad_window
    $error("fft_peak_tracker: MAX_BIN must be < 1024 and >= MIN_BIN");
  end
  if (STABLE_FRAMES < 1 || STABLE_FRAMES > 15) begin : g_bad_stable
    $error("fft_peak_tracker: STABLE_FRAMES must be in 1..15");
  end
  if (TOLERANCE > 1023) begin : g_bad_tol
    $error("fft_peak_tracker: TOLERANCE must be < 1024");
  end

  localparam logic [11:0] MIN_BIN_12 = 12'(MIN_BIN);
  localparam logic [11:0] MAX_BIN_12 = 12'(MAX_BIN);
  localparam logic [9:0]  MIN_BIN_10 = 10'(MIN_BIN);

  typedef enum logic [1:0] {
    WAIT_START = 2'd0,
    SCAN       = 2'd1,
    EVAL       = 2'd2
  } state_e;

  // Frame FSM and running maximum.
  state_e      state_q, state_d;
  logic [23:0] max_mag_q, max_mag_d;
  logic [9:0]  max_bin_q, max_bin_d;
  logic        frame_err_q, frame_err_d;

  // Beat classification.
  logic        beat_start_s;
  logic        beat_qual_s;
  logic        beat_gt_run_s;
  logic        beat_nonzero_s;
  logic        eval_s;

  // Evaluation results, computed from the snapshot during EVAL.
  logic        present_s;
  logic        stable_s;
  logic        load_s;

  // First pipeline stage after EVAL.
  logic        s1_valid_q;
  logic [9:0]  s1_bin_q;
  logic [23:0] s1_mag_q;
  logic        s1_present_q;
  logic        s1_stable_q;
  logic        s1_load_q;

  // Output registers.
  logic [9:0]  peak_bin_q;
  logic [23:0] peak_mag_q;
  logic        peak_valid_q;
  logic        peak_present_q;
  logic        note_stable_q;
  logic [9:0]  stable_bin_q;

  // Classify the incoming beat against the frame start marker and pitch window.
  always_comb begin
    beat_start_s   = magnitude_tvalid && (magnitude_tuser == 12'd0);
    beat_qual_s    = magnitude_tvalid &&
                     (magnitude_tuser >= MIN_BIN_12) &&
                     (magnitude_tuser <= MAX_BIN_12);
    beat_gt_run_s  = beat_qual_s && (magnitude_tdata > max_mag_q);
    // A new frame starts from magnitude 0, so any non-zero qualifying beat wins.
    beat_nonzero_s = beat_qual_s && (magnitude_tdata != 24'd0);
  end

  // Frame FSM next-state, running-max update and abort detection.
  always_comb begin
    state_d     = state_q;
    max_mag_d   = max_mag_q;
    max_bin_d   = max_bin_q;
    frame_err_d = 1'b0;
    eval_s      = 1'b0;
    case (state_q)
      WAIT_START: begin
        if (beat_start_s) begin
          max_mag_d = beat_nonzero_s ? magnitude_tdata : 24'd0;
          max_bin_d = beat_nonzero_s ? magnitude_tuser[9:0] : MIN_BIN_10;
          state_d   = magnitude_tlast ? EVAL : SCAN;
        end else begin
          state_d = WAIT_START;
        end
      end
      SCAN: begin
        if (magnitude_tvalid && magnitude_tlast) begin
          // The tlast beat joins the comparison before the snapshot.
          if (beat_gt_run_s) begin
            max_mag_d = magnitude_tdata;
            max_bin_d = magnitude_tuser[9:0];
          end else begin
            max_mag_d = max_mag_q;
          end
          state_d = EVAL;
        end else if (beat_start_s) begin
          // Bin 0 reappeared without tlast: abort and rescan from this beat.
          frame_err_d = 1'b1;
          max_mag_d   = beat_nonzero_s ? magnitude_tdata : 24'd0;
          max_bin_d   = beat_nonzero_s ? magnitude_tuser[9:0] : MIN_BIN_10;
          state_d     = SCAN;
        end else if (beat_gt_run_s) begin
          max_mag_d = magnitude_tdata;
          max_bin_d = magnitude_tuser[9:0];
        end else begin
          state_d = SCAN;
        end
      end
      EVAL: begin
        eval_s = 1'b1;
        // A back-to-back frame may begin in the same cycle as the publish.
        if (beat_start_s) begin
          max_mag_d = beat_nonzero_s ? magnitude_tdata : 24'd0;
          max_bin_d = beat_nonzero_s ? magnitude_tuser[9:0] : MIN_BIN_10;
          state_d   = magnitude_tlast ? EVAL : SCAN;
        end else begin
          state_d = WAIT_START;
        end
      end
      default: begin
        state_d = WAIT_START;
      end
    endcase
  end

  // Register the FSM, the running maximum and the abort pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_START;
      max_mag_q   <= 24'd0;
      max_bin_q   <= MIN_BIN_10;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      max_mag_q   <= max_mag_d;
      max_bin_q   <= max_bin_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Compare the snapshot against the noise threshold.
  always_comb begin
    present_s = (max_mag_q > THRESHOLD);
  end

`ifdef FFT_PEAK_STABILITY_EN
  logic [3:0]         cnt_q, cnt_d;
  logic [9:0]         prev_bin_q;
  logic               prev_present_q;
  logic signed [10:0] diff_s;
  logic [10:0]        abs_diff_s;
  logic               near_s;

  // Compute the bin distance from the previous frame and the next count.
  always_comb begin
    diff_s     = $signed({1'b0, max_bin_q}) - $signed({1'b0, prev_bin_q});
    abs_diff_s = diff_s[10] ? $unsigned(11'sd0 - diff_s) : $unsigned(diff_s);
    near_s     = (abs_diff_s <= 11'(TOLERANCE));
    if (present_s && near_s && prev_present_q) begin
      cnt_d = (cnt_q < 4'(STABLE_FRAMES)) ? (cnt_q + 4'd1) : cnt_q;
    end else if (present_s) begin
      cnt_d = 4'd1;
    end else begin
      cnt_d = 4'd0;
    end
    stable_s = (cnt_d >= 4'(STABLE_FRAMES));
    load_s   = stable_s;
  end

  // Update the stability counter and the previous-frame memory on each EVAL.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= 4'd0;
      prev_bin_q     <= 10'd0;
      prev_present_q <= 1'b0;
    end else if (eval_s) begin
      cnt_q          <= cnt_d;
      prev_bin_q     <= max_bin_q;
      prev_present_q <= present_s;
    end else begin
      cnt_q          <= cnt_q;
      prev_bin_q     <= prev_bin_q;
      prev_present_q <= prev_present_q;
    end
  end
`else
  // Without the counter, note status simply follows the current peak.
  always_comb begin
    stable_s = present_s;
    load_s   = 1'b1;
  end
`endif

  // Stage the EVAL results one cycle ahead of the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_bin_q     <= 10'd0;
      s1_mag_q     <= 24'd0;
      s1_present_q <= 1'b0;
      s1_stable_q  <= 1'b0;
      s1_load_q    <= 1'b0;
    end else begin
      s1_valid_q <= eval_s;
      if (eval_s) begin
        s1_bin_q     <= max_bin_q;
        s1_mag_q     <= max_mag_q;
        s1_present_q <= present_s;
        s1_stable_q  <= stable_s;
        s1_load_q    <= load_s;
      end
    end
  end

  // Publish the staged results and hold them until the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_bin_q     <= 10'd0;
      peak_mag_q     <= 24'd0;
      peak_valid_q   <= 1'b0;
      peak_present_q <= 1'b0;
      note_stable_q  <= 1'b0;
      stable_bin_q   <= 10'd0;
    end else begin
      peak_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        peak_bin_q     <= s1_bin_q;
        peak_mag_q     <= s1_mag_q;
        peak_present_q <= s1_present_q;
        note_stable_q  <= s1_stable_q;
        if (s1_load_q) begin
          stable_bin_q <= s1_bin_q;
        end
      end
    end
  end

  assign peak_bin     = peak_bin_q;
  assign peak_mag     = peak_mag_q;
  assign peak_valid   = peak_valid_q;
  assign peak_present = peak_present_q;
  assign note_stable  = note_stable_q;
  assign stable_bin   = stable_bin_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_fft_peak_tracker.sv
module tb_fft_peak_tracker;

  localparam int FLEN = 640;
  localparam int NV   = 11;
  localparam logic [11:0] NONE = 12'hFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] magnitude_tdata;
  logic [11:0] magnitude_tuser;
  logic        magnitude_tlast;
  logic        magnitude_tvalid;
  logic [9:0]  peak_bin;
  logic [23:0] peak_mag;
  logic        peak_valid;
  logic        peak_present;
  logic        note_stable;
  logic [9:0]  stable_bin;
  logic        frame_err;

  always #5 clk = ~clk;

  fft_peak_tracker dut (
    .clk              (clk),
    .reset            (reset),
    .magnitude_tdata  (magnitude_tdata),
    .magnitude_tuser  (magnitude_tuser),
    .magnitude_tlast  (magnitude_tlast),
    .magnitude_tvalid (magnitude_tvalid),
    .peak_bin         (peak_bin),
    .peak_mag         (peak_mag),
    .peak_valid       (peak_valid),
    .peak_present     (peak_present),
    .note_stable      (note_stable),
    .stable_bin       (stable_bin),
    .frame_err        (frame_err)
  );

  typedef struct {
    logic [23:0] base;
    logic [11:0] ob0; logic [23:0] om0;
    logic [11:0] ob1; logic [23:0] om1;
    logic [11:0] ob2; logic [23:0] om2;
    logic [11:0] ob3; logic [23:0] om3;
    logic [9:0]  exp_bin;
    logic [23:0] exp_mag;
    logic        exp_pres;
    logic        exp_stab;   // with the stability counter compiled in
    logic [9:0]  exp_sbin;   // with the stability counter compiled in
  } vec_t;

  vec_t vec [NV];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pv_cnt   = 0;
  int fe_cnt   = 0;
  int pv_cyc [$];
  logic [9:0] pv_bin [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (peak_valid) begin
      pv_cnt <= pv_cnt + 1;
      pv_cyc.push_back(cyc);
      pv_bin.push_back(peak_bin);
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic beat(input int bin, input logic [23:0] mag, input logic last);
    @(negedge clk);
    magnitude_tvalid = 1'b1;
    magnitude_tuser  = 12'(bin);
    magnitude_tdata  = mag;
    magnitude_tlast  = last;
  endtask

  // Waits for the peak_valid pulse after a tlast beat; returns negedges elapsed (0 = timeout).
  task automatic wait_pulse(output int lat);
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      magnitude_tvalid = 1'b0;
      magnitude_tlast  = 1'b0;
      if (peak_valid) lat = i;
    end
  endtask

  function automatic logic [23:0] vmag(input vec_t v, input int b);
    logic [11:0] bb;
    bb = 12'(b);
    if (bb == v.ob0) return v.om0;
    if (bb == v.ob1) return v.om1;
    if (bb == v.ob2) return v.om2;
    if (bb == v.ob3) return v.om3;
    return v.base;
  endfunction

  initial begin
    int lat;
    int pv0;
    int fe0;
    logic exp_stab;
    logic [9:0] exp_sbin;

    // base, 4 overrides, peak bin, peak mag, present, stable, stable_bin
    vec[0]  = '{24'h000100, 12'd100, 24'h005000, NONE, 24'h0, NONE, 24'h0, NONE, 24'h0,
                10'd100, 24'h005000, 1'b1, 1'b0, 10'd0};
    vec[1]  = '{24'h000000, 12'd2, 24'hFFFFFF, 12'd50, 24'h002000, 12'd60, 24'h002000, 12'd600, 24'hFFFFFF,
                10'd50, 24'h002000, 1'b1, 1'b0, 10'd0};
    vec[2]  = '{24'h000000, 12'd300, 24'h000400, NONE, 24'h0, NONE, 24'h0, NONE, 24'h0,
                10'd300, 24'h000400, 1'b0, 1'b0, 10'd0};
    vec[3]  = '{24'h000000, 12'd300, 24'h000401, NONE, 24'h0, NONE, 24'h0, NONE, 24'h0,
                10'd300, 24'h000401, 1'b1, 1'b0, 10'd0};
    vec[4]  = '{24'h000000, 12'd200, 24'h008000, NONE, 24'h0, NONE, 24'h0, NONE, 24'h0,
                10'd200, 24'h008000, 1'b1, 1'b0, 10'd0};
    vec[5]  = '{24'h000000, 12'd201, 24'h008000, NONE, 24'h0, NONE, 24'h0, NONE, 24'h0,
                10'd201, 24'h008000, 1'b1, 1'b0, 10'd0};
    vec[6]  = '{24'h000000, 12'd200, 24'h008000, NONE, 24'h0, NONE, 24'h0, NONE, 24'h0,
                10'd200, 24'h008000, 1'b1, 1'b1, 10'd200};
    vec[7]  = '{24'h000000, 12'd210, 24'h008000, NONE, 24'h0, NONE, 24'h0, NONE, 24'h0,
                10'd210, 24'h008000, 1'b1, 1'b0, 10'd200};
    vec[8]  = '{24'h000000, NONE, 24'h0, NONE, 24'h0, NONE, 24'h0, NONE, 24'h0,
                10'd4, 24'h000000, 1'b0, 1'b0, 10'd200};
    vec[9]  = '{24'h000500, NONE, 24'h0, NONE, 24'h0, NONE, 24'h0, NONE, 24'h0,
                10'd4, 24'h000500, 1'b1, 1'b0, 10'd200};
    vec[10] = '{24'h000000, 12'd511, 24'h000600, 12'd512, 24'h000700, NONE, 24'h0, NONE, 24'h0,
                10'd511, 24'h000600, 1'b1, 1'b0, 10'd200};

    reset = 1'b1;
    magnitude_tvalid = 1'b0;
    magnitude_tlast  = 1'b0;
    magnitude_tuser  = 12'd0;
    magnitude_tdata  = 24'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_peak_bin", 32'(peak_bin), 32'd0);
    chk("rst_peak_mag", 32'(peak_mag), 32'd0);
    chk("rst_outputs", {27'd0, peak_valid, peak_present, note_stable, frame_err, 1'b0}, 32'd0);
    chk("rst_stable_bin", 32'(stable_bin), 32'd0);

    // Table-driven frames.
    for (int v = 0; v < NV; v++) begin
      for (int b = 0; b < FLEN; b++) beat(b, vmag(vec[v], b), b == FLEN - 1);
      wait_pulse(lat);
`ifdef FFT_PEAK_STABILITY_EN
      exp_stab = vec[v].exp_stab;
      exp_sbin = vec[v].exp_sbin;
`else
      exp_stab = vec[v].exp_pres;
      exp_sbin = vec[v].exp_bin;
`endif
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'd3);
      chk($sformatf("v%0d_peak_bin", v), 32'(peak_bin), 32'(vec[v].exp_bin));
      chk($sformatf("v%0d_peak_mag", v), 32'(peak_mag), 32'(vec[v].exp_mag));
      chk($sformatf("v%0d_present", v), 32'(peak_present), 32'(vec[v].exp_pres));
      chk($sformatf("v%0d_note_stable", v), 32'(note_stable), 32'(exp_stab));
      chk($sformatf("v%0d_stable_bin", v), 32'(stable_bin), 32'(exp_sbin));
      @(negedge clk);
      chk($sformatf("v%0d_pulse_width", v), 32'(peak_valid), 32'd0);
    end
    chk("table_pulse_count", 32'(pv_cnt), 32'(NV));
    chk("table_no_frame_err", 32'(fe_cnt), 32'd0);

    // Missing tlast: bins 0..2000 then bin 0 again aborts the frame.
    pv0 = pv_cnt;
    for (int b = 0; b <= 2000; b++) beat(b, 24'h000100, 1'b0);
    beat(0, 24'h000100, 1'b0);
    @(negedge clk);
    magnitude_tvalid = 1'b0;
    chk("abort_frame_err", 32'(frame_err), 32'd1);
    @(negedge clk);
    chk("abort_err_width", 32'(frame_err), 32'd0);
    for (int b = 1; b < FLEN; b++) beat(b, (b == 100) ? 24'h003000 : 24'h000100, b == FLEN - 1);
    wait_pulse(lat);
    chk("abort_next_latency", 32'(lat), 32'd3);
    chk("abort_next_bin", 32'(peak_bin), 32'd100);
    chk("abort_next_mag", 32'(peak_mag), 32'h003000);
    @(negedge clk);
    chk("abort_pulse_count", 32'(pv_cnt - pv0), 32'd1);
    chk("abort_err_count", 32'(fe_cnt), 32'd1);

    // Reset mid-frame, ignored beats, then two gapless full frames.
    pv0 = pv_cnt;
    fe0 = fe_cnt;
    for (int b = 0; b <= 1500; b++) beat(b, 24'h00F000, 1'b0);
    @(negedge clk);
    magnitude_tvalid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_peak_mag", 32'(peak_mag), 32'd0);
    chk("midrst_outputs", {28'd0, peak_valid, peak_present, note_stable, frame_err}, 32'd0);
    for (int b = 1501; b <= 1600; b++) beat(b, 24'hFFFFFF, 1'b0);
    for (int b = 0; b < 4096; b++) beat(b, (b == 10) ? 24'h009000 : 24'h000000, b == 4095);
    for (int b = 0; b < 4096; b++) beat(b, (b == 20) ? 24'h007000 : 24'h000000, b == 4095);
    wait_pulse(lat);
    chk("b2b_latency", 32'(lat), 32'd3);
    chk("b2b_last_mag", 32'(peak_mag), 32'h007000);
    repeat (2) @(negedge clk);
    chk("b2b_pulse_count", 32'(pv_cnt - pv0), 32'd2);
    chk("b2b_err_count", 32'(fe_cnt - fe0), 32'd0);
    if (pv_cyc.size() >= 2) begin
      chk("b2b_spacing", 32'(pv_cyc[pv_cyc.size()-1] - pv_cyc[pv_cyc.size()-2]), 32'd4096);
      chk("b2b_first_bin", 32'(pv_bin[pv_bin.size()-2]), 32'd10);
      chk("b2b_second_bin", 32'(pv_bin[pv_bin.size()-1]), 32'd20);
    end else begin
      chk("b2b_pulses_recorded", 32'(pv_cyc.size()), 32'd2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
